alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU control/operand interface: decodes a 32-bit RV32 instruction plus register
//  read data into the 4-bit ALU control code and the two ALU operands, and holds them in the ID/EX register.
//  It sits between register-file read and the ALU. Valid/ready on both sides; a 2-entry skid buffer gives
//  full throughput with a registered in_ready_o. One cycle of latency, plus a flush for branch/hazard squash.
// PARAMETERS
//  DATA_W        32       operand width (immediates sign-extended to DATA_W)
//  ILLEGAL_CODE  4'b1111  ALU control emitted for undecodable instructions (ALU then outputs 0)
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  rst_i          in   1       reset, asynchronous, active-high
//  flush_i        in   1       squash all held entries and the current input
//  in_valid_i     in   1       instruction/operands valid
//  in_ready_o     out  1       stage can accept (registered)
//  instr_i        in   32      instruction word
//  rs1_data_i     in   DATA_W  register rs1 read data
//  rs2_data_i     in   DATA_W  register rs2 read data
//  out_valid_o    out  1       ALU inputs valid
//  out_ready_i    in   1       ALU/EX consumer accepts
//  alu_ctrl_o     out  4       ALU control code
//  data1_o        out  DATA_W  ALU operand 1 (= rs1_data)
//  data2_o        out  DATA_W  ALU operand 2 (rs2_data or immediate)
//  br_imm_o       out  DATA_W  B-type offset, sign-extended; 0 for other types
//  illegal_o      out  1       instruction not decodable
// BEHAVIOUR
//  Decode (opcode[6:0], funct3[14:12], funct7[31:25]) -> alu_ctrl, data2:
//   0110011 f7=0000000 f3=110 -> 0000 or  ; f3=111 -> 0001 and ; f3=000 -> 0010 add ; data2=rs2
//   0110011 f7=0100000 f3=000 -> 0011 sub ; f7=0000001 f3=000 -> 0100 mul ; data2=rs2
//   0010011 f3=000 -> 0101 addi ; 0000011 f3=010 -> 0110 ld ; data2=sext(instr[31:20])
//   0100011 f3=010 -> 0111 sd ; data2=sext({instr[31:25],instr[11:7]})
//   1100011 f3=000 -> 1000 beq ; data2=rs2 ; br_imm=sext({i[31],i[7],i[30:25],i[11:8],1'b0})
//   anything else -> ILLEGAL_CODE, illegal_o=1, data1/data2 pass rs1/rs2 unchanged
//  Buffer: main entry (drives outputs) + skid entry. in_ready_o = !skid_valid (registered).
//   accept = in_valid_i & in_ready_o & !flush_i; drain = out_valid_o & out_ready_i.
//   accept with main empty or draining -> into main; accept with main held -> into skid.
//   drain with skid valid -> skid moves to main the same edge; order strictly FIFO.
//  Latency: accepted instruction appears on outputs on the next edge at the earliest.
//  Outputs stable while out_valid_o=1 and out_ready_i=0 (no change, no drop).
//  flush_i: next edge clears main and skid valid; an input in the same cycle is discarded; a drain in
//   the same cycle still counts as consumed by the ALU.
//  Reset (async, immediate): out_valid_o=0, in_ready_o=1, alu_ctrl_o=0000, data1/data2/br_imm=0,
//   illegal_o=0, skid empty. Reset mid-transfer loses all held entries.
//  Payload registers load only on accept (no enable when idle); valid bits are the only control state.
// STRUCTURE
//  alu_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), ALU codes ALU_OR..ALU_BEQ,
//   ILLEGAL_CODE default; shared with the ALU so both ends agree on encodings.
//  Sub-module alu_ctrl_decode (combinational: instr, rs1, rs2 -> ctrl, data2, br_imm, illegal);
//   alu_issue_stage instantiates it once and contains only the 2-entry buffer and handshake.
// TESTING
//  1 add x3,x1,x2 (0x002081B3) rs1=5 rs2=7, out_ready=1 -> next cycle ctrl=0010 data1=5 data2=7 illegal=0
//  2 addi imm=-1 (0xFFF00093) rs1=10 -> ctrl=0101 data2=0xFFFFFFFF; sd off=-4 -> ctrl=0111 data2=0xFFFFFFFC
//  3 beq off=+8 (0x00208463) -> ctrl=1000 data2=rs2 br_imm=8; opcode 0x7F -> ctrl=1111 illegal=1
//  4 out_ready=0 for 3 cycles, stream 3 instrs -> 2 held, in_ready drops after 2nd, outputs frozen;
//    release -> drain in order, no loss or duplication, in_ready back to 1
//  5 flush_i with 2 held entries + in_valid -> next cycle out_valid=0, in_ready=1, input not emitted
//  6 rst_i asserted mid-stall (not on an edge) -> outputs zero immediately; after release, 1st instr
//    accepted normally; random valid/ready bench vs reference FIFO model, 10k instrs, zero mismatches

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Opcode and ALU control encodings shared by the issue stage and the ALU.
package alu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_OR   = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_MUL  = 4'b0100,
    ALU_ADDI = 4'b0101,
    ALU_LD   = 4'b0110,
    ALU_SD   = 4'b0111,
    ALU_BEQ  = 4'b1000
  } alu_ctrl_e;

  // The ALU treats this code as "output zero"; both ends must agree on it.
  localparam logic [3:0] ILLEGAL_CODE_DEFAULT = 4'b1111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - Combinational RV32 subset decode into ALU control code and operands.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int         DATA_W       = 32,
  parameter logic [3:0] ILLEGAL_CODE = ILLEGAL_CODE_DEFAULT
) (
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic [3:0]        ctrl_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] br_imm_o,
  output logic              illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [DATA_W-1:0] imm_i_ext;
  logic [DATA_W-1:0] imm_s_ext;
  logic [DATA_W-1:0] imm_b_ext;
  logic              unused_rs1_field;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // rs1 index is resolved by the register file upstream; only its data arrives here.
  assign unused_rs1_field = ^instr_i[19:15];

  assign imm_i_ext = {{(DATA_W-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s_ext = {{(DATA_W-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_ext = {{(DATA_W-13){instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};

  assign data1_o = rs1_data_i;

  always_comb begin
    ctrl_o    = ILLEGAL_CODE;
    data2_o   = rs2_data_i;
    br_imm_o  = '0;
    illegal_o = 1'b1;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE && funct3 == 3'b110) begin
          ctrl_o    = ALU_OR;
          illegal_o = 1'b0;
        end else if (funct7 == F7_BASE && funct3 == 3'b111) begin
          ctrl_o    = ALU_AND;
          illegal_o = 1'b0;
        end else if (funct7 == F7_BASE && funct3 == 3'b000) begin
          ctrl_o    = ALU_ADD;
          illegal_o = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          ctrl_o    = ALU_SUB;
          illegal_o = 1'b0;
        end else if (funct7 == F7_MUL && funct3 == 3'b000) begin
          ctrl_o    = ALU_MUL;
          illegal_o = 1'b0;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          ctrl_o    = ALU_ADDI;
          data2_o   = imm_i_ext;
          illegal_o = 1'b0;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          ctrl_o    = ALU_LD;
          data2_o   = imm_i_ext;
          illegal_o = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          ctrl_o    = ALU_SD;
          data2_o   = imm_s_ext;
          illegal_o = 1'b0;
        end
      end
      OP_BRANCH: begin
        // Comparison runs in the ALU on rs1/rs2; the offset travels separately.
        if (funct3 == 3'b000) begin
          ctrl_o    = ALU_BEQ;
          br_imm_o  = imm_b_ext;
          illegal_o = 1'b0;
        end
      end
      default: begin
        ctrl_o = ILLEGAL_CODE;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX register with 2-entry skid buffer feeding the ALU.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int         DATA_W       = 32,
  parameter logic [3:0] ILLEGAL_CODE = ILLEGAL_CODE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] br_imm_o,
  output logic              illegal_o
);

  logic [3:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_data1;
  logic [DATA_W-1:0] dec_data2;
  logic [DATA_W-1:0] dec_br_imm;
  logic              dec_illegal;

  logic              main_valid;
  logic [3:0]        main_ctrl;
  logic [DATA_W-1:0] main_data1;
  logic [DATA_W-1:0] main_data2;
  logic [DATA_W-1:0] main_br_imm;
  logic              main_illegal;

  logic              skid_valid;
  logic [3:0]        skid_ctrl;
  logic [DATA_W-1:0] skid_data1;
  logic [DATA_W-1:0] skid_data2;
  logic [DATA_W-1:0] skid_br_imm;
  logic              skid_illegal;

  logic accept;
  logic drain;
  logic main_from_skid;
  logic main_from_input;
  logic skid_from_input;

  alu_ctrl_decode #(
    .DATA_W       (DATA_W),
    .ILLEGAL_CODE (ILLEGAL_CODE)
  ) u_decode (
    .instr_i    (instr_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .ctrl_o     (dec_ctrl),
    .data1_o    (dec_data1),
    .data2_o    (dec_data2),
    .br_imm_o   (dec_br_imm),
    .illegal_o  (dec_illegal)
  );

  // Ready depends only on skid occupancy, so it is a flop output with no input-to-ready path.
  assign in_ready_o = ~skid_valid;

  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign drain  = main_valid & out_ready_i;

  // When the skid is full, in_ready is low, so accept and skid-refill never coincide.
  always_comb begin
    main_from_skid  = 1'b0;
    main_from_input = 1'b0;
    skid_from_input = 1'b0;
    if (!flush_i) begin
      if (drain && skid_valid) begin
        main_from_skid = 1'b1;
      end else if (accept && (!main_valid || drain)) begin
        main_from_input = 1'b1;
      end else if (accept) begin
        skid_from_input = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_from_skid || main_from_input) begin
        main_valid <= 1'b1;
      end else if (drain) begin
        main_valid <= 1'b0;
      end
      if (main_from_skid) begin
        skid_valid <= 1'b0;
      end else if (skid_from_input) begin
        skid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ctrl    <= '0;
      main_data1   <= '0;
      main_data2   <= '0;
      main_br_imm  <= '0;
      main_illegal <= 1'b0;
    end else if (main_from_skid) begin
      main_ctrl    <= skid_ctrl;
      main_data1   <= skid_data1;
      main_data2   <= skid_data2;
      main_br_imm  <= skid_br_imm;
      main_illegal <= skid_illegal;
    end else if (main_from_input) begin
      main_ctrl    <= dec_ctrl;
      main_data1   <= dec_data1;
      main_data2   <= dec_data2;
      main_br_imm  <= dec_br_imm;
      main_illegal <= dec_illegal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_ctrl    <= '0;
      skid_data1   <= '0;
      skid_data2   <= '0;
      skid_br_imm  <= '0;
      skid_illegal <= 1'b0;
    end else if (skid_from_input) begin
      skid_ctrl    <= dec_ctrl;
      skid_data1   <= dec_data1;
      skid_data2   <= dec_data2;
      skid_br_imm  <= dec_br_imm;
      skid_illegal <= dec_illegal;
    end
  end

  assign out_valid_o = main_valid;
  assign alu_ctrl_o  = main_ctrl;
  assign data1_o     = main_data1;
  assign data2_o     = main_data2;
  assign br_imm_o    = main_br_imm;
  assign illegal_o   = main_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - Directed and randomized handshake bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] br_imm;
  logic        illegal;

  int tests_run;
  int tests_failed;

  localparam int NVEC = 11;
  logic [31:0] vec_instr   [NVEC];
  logic [3:0]  vec_ctrl    [NVEC];
  logic        vec_use_rs2 [NVEC];
  logic [31:0] vec_imm     [NVEC];
  logic [31:0] vec_br      [NVEC];
  logic        vec_ill     [NVEC];

  alu_issue_stage #(
    .DATA_W       (32),
    .ILLEGAL_CODE (4'b1111)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .instr_i     (instr),
    .rs1_data_i  (rs1_data),
    .rs2_data_i  (rs2_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_ctrl_o  (alu_ctrl),
    .data1_o     (data1),
    .data2_o     (data2),
    .br_imm_o    (br_imm),
    .illegal_o   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [3:0] c, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] br,
                                        input logic il);
    return {27'b0, c, d1, d2, br, il};
  endfunction

  function automatic logic [127:0] expect_vec(input int idx, input logic [31:0] r1,
                                              input logic [31:0] r2);
    return pack(vec_ctrl[idx], r1, vec_use_rs2[idx] ? r2 : vec_imm[idx], vec_br[idx], vec_ill[idx]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic set_vec(input int i, input logic [31:0] ins, input logic [3:0] c,
                         input logic use_rs2, input logic [31:0] imm,
                         input logic [31:0] br, input logic il);
    vec_instr[i]   = ins;
    vec_ctrl[i]    = c;
    vec_use_rs2[i] = use_rs2;
    vec_imm[i]     = imm;
    vec_br[i]      = br;
    vec_ill[i]     = il;
  endtask

  initial begin
    logic [127:0] q[$];
    logic [31:0]  r1;
    logic [31:0]  r2;
    int           accepted;
    int           cycles;
    int           idx;
    logic         acc;
    logic         drn;

    tests_run    = 0;
    tests_failed = 0;

    set_vec(0,  32'h002081B3, 4'b0010, 1'b1, 32'h0,        32'h0, 1'b0); // add
    set_vec(1,  32'h40208133, 4'b0011, 1'b1, 32'h0,        32'h0, 1'b0); // sub
    set_vec(2,  32'h02208133, 4'b0100, 1'b1, 32'h0,        32'h0, 1'b0); // mul
    set_vec(3,  32'h0020E133, 4'b0000, 1'b1, 32'h0,        32'h0, 1'b0); // or
    set_vec(4,  32'h0020F133, 4'b0001, 1'b1, 32'h0,        32'h0, 1'b0); // and
    set_vec(5,  32'hFFF00093, 4'b0101, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0); // addi -1
    set_vec(6,  32'h01012083, 4'b0110, 1'b0, 32'h00000010, 32'h0, 1'b0); // lw +16
    set_vec(7,  32'hFE20AE23, 4'b0111, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0); // sw -4
    set_vec(8,  32'h00208463, 4'b1000, 1'b1, 32'h0,        32'h8, 1'b0); // beq +8
    set_vec(9,  32'h0000007F, 4'b1111, 1'b1, 32'h0,        32'h0, 1'b1); // bad opcode
    set_vec(10, 32'h02209133, 4'b1111, 1'b1, 32'h0,        32'h0, 1'b1); // mulh unsupported

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    step();
    step();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_payload", pack(alu_ctrl, data1, data2, br_imm, illegal), '0);
    rst = 1'b0;
    step();

    // Single-instruction decode of every table entry with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      r1 = (i == 0) ? 32'd5 : ((i == 5) ? 32'd10 : 32'hA000_0000 + i);
      r2 = (i == 0) ? 32'd7 : 32'h5000_0000 + i;
      drive(vec_instr[i], r1, r2);
      step();
      in_valid = 1'b0;
      check($sformatf("dec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("dec%0d_payload", i), pack(alu_ctrl, data1, data2, br_imm, illegal),
            expect_vec(i, r1, r2));
      step();
      check($sformatf("dec%0d_drained", i), out_valid, 1'b0);
    end

    // Backpressure: two entries held, third blocked, outputs frozen, FIFO drain.
    out_ready = 1'b0;
    drive(vec_instr[0], 32'h100, 32'h1);
    step();
    check("stall_a_valid", out_valid, 1'b1);
    check("stall_a_ready", in_ready, 1'b1);
    drive(vec_instr[0], 32'h200, 32'h2);
    step();
    check("stall_b_ready", in_ready, 1'b0);
    check("stall_b_hold", data1, 32'h100);
    drive(vec_instr[0], 32'h300, 32'h3);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_c_ready", in_ready, 1'b0);
      check("stall_frozen", pack(alu_ctrl, data1, data2, br_imm, illegal),
            pack(4'b0010, 32'h100, 32'h1, 32'h0, 1'b0));
    end
    out_ready = 1'b1;
    step();
    check("release_b", data1, 32'h200);
    check("release_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("release_c", data1, 32'h300);
    check("release_c_valid", out_valid, 1'b1);
    step();
    check("release_empty", out_valid, 1'b0);
    check("release_ready_end", in_ready, 1'b1);

    // Flush with both entries held and a new input presented.
    out_ready = 1'b0;
    drive(vec_instr[0], 32'h400, 32'h4);
    step();
    drive(vec_instr[0], 32'h500, 32'h5);
    step();
    drive(vec_instr[0], 32'h600, 32'h6);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_no_emit", out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of a stall, then normal operation.
    out_ready = 1'b0;
    drive(vec_instr[5], 32'h700, 32'h7);
    step();
    in_valid = 1'b0;
    check("prerst_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b1);
    check("async_rst_payload", pack(alu_ctrl, data1, data2, br_imm, illegal), '0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    drive(vec_instr[8], 32'h800, 32'h8);
    step();
    in_valid = 1'b0;
    check("postrst_payload", pack(alu_ctrl, data1, data2, br_imm, illegal),
          expect_vec(8, 32'h800, 32'h8));
    step();
    check("postrst_empty", out_valid, 1'b0);

    // Random valid/ready traffic against a reference FIFO of decoded expectations.
    accepted = 0;
    cycles   = 0;
    q.delete();
    while ((accepted < 10000 || q.size() > 0) && cycles < 80000) begin
      idx = $urandom_range(0, NVEC - 1);
      r1  = $urandom;
      r2  = $urandom;
      instr     = vec_instr[idx];
      rs1_data  = r1;
      rs2_data  = r2;
      in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      check("rnd_out_valid", out_valid, q.size() > 0);
      check("rnd_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0)
        check("rnd_payload", pack(alu_ctrl, data1, data2, br_imm, illegal), q[0]);
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      step();
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(expect_vec(idx, r1, r2));
        accepted++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    check("rnd_accepted", accepted, 10000);
    check("rnd_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
